// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI3 encodings, widths and responder state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam int AXI_LEN_W  = 8;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef logic [1:0] resp_state_t;

    localparam resp_state_t S_IDLE  = 2'd0;
    localparam resp_state_t S_READ  = 2'd1;
    localparam resp_state_t S_WDATA = 2'd2;
    localparam resp_state_t S_BRESP = 2'd3;

    // Only power-of-two wrap lengths get wrap addressing; others fall back to INCR.
    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_mem
// Description : Single-port 32-bit RAM with byte enables and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_mem
    import axi_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [AXI_DATA_W-1:0] wdata,
    output logic [AXI_DATA_W-1:0] rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [AXI_DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic [AXI_DATA_W-1:0] r_rdata;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            always_ff @(posedge clk) begin
                if (en && we[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    endgenerate

    // Output register holds its value on idle cycles, which keeps stalled read data stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (en && (we == 4'b0000)) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_responder
// Description : AXI3 slave terminating one burst at a time into an internal RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int ID_WIDTH       = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [31:0]           s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [ID_WIDTH-1:0]   s_axi_wid,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready
);

    localparam int c_IDX_W = MEM_WORDS_LOG2;

    resp_state_t            r_state;
    logic [ID_WIDTH-1:0]    r_id;
    logic [c_IDX_W-1:0]     r_idx;
    logic [AXI_LEN_W-1:0]   r_len;
    logic [1:0]             r_burst;
    logic [AXI_LEN_W-1:0]   r_beat;
    logic                   r_err;

    logic                   w_idle;
    logic                   w_aw_hs;
    logic                   w_ar_hs;
    logic                   w_last_beat;
    logic [c_IDX_W-1:0]     w_ar_idx;
    logic [c_IDX_W-1:0]     w_aw_idx;
    logic [c_IDX_W-1:0]     w_next_idx;

    logic                   w_mem_en;
    logic [3:0]             w_mem_we;
    logic [c_IDX_W-1:0]     w_mem_addr;
    logic [AXI_DATA_W-1:0]  w_mem_rdata;

    logic                   w_unused;

    function automatic logic [c_IDX_W-1:0] next_idx(
        input logic [c_IDX_W-1:0]   idx,
        input logic [AXI_LEN_W-1:0] len,
        input logic [1:0]           burst
    );
        logic [c_IDX_W-1:0] inc;
        logic [c_IDX_W-1:0] mask;
        inc  = idx + 1'b1;
        mask = c_IDX_W'(len);
        if (burst == AXI_BURST_FIXED) begin
            return idx;
        end else if ((burst == AXI_BURST_WRAP) && wrap_len_ok(len)) begin
            return (idx & ~mask) | (inc & mask);
        end else begin
            return inc;
        end
    endfunction

    assign w_ar_idx    = s_axi_araddr[MEM_WORDS_LOG2+1:2];
    assign w_aw_idx    = s_axi_awaddr[MEM_WORDS_LOG2+1:2];
    assign w_next_idx  = next_idx(r_idx, r_len, r_burst);
    assign w_last_beat = (r_beat == r_len);

    // Readies are held low while reset is asserted so nothing is accepted mid-reset.
    assign w_idle  = (r_state == S_IDLE) && !reset;
    assign w_aw_hs = w_idle && s_axi_awvalid;
    assign w_ar_hs = w_idle && s_axi_arvalid && !s_axi_awvalid;

    assign s_axi_awready = w_idle;
    assign s_axi_arready = w_idle && !s_axi_awvalid;
    assign s_axi_wready  = (r_state == S_WDATA) && !reset;

    assign s_axi_rvalid  = (r_state == S_READ);
    assign s_axi_rlast   = s_axi_rvalid && w_last_beat;
    assign s_axi_rid     = r_id;
    assign s_axi_rresp   = AXI_RESP_OKAY;
    assign s_axi_rdata   = w_mem_rdata;

    assign s_axi_bvalid  = (r_state == S_BRESP);
    assign s_axi_bid     = r_id;
    assign s_axi_bresp   = (s_axi_bvalid && r_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // One RAM access per cycle: AR lookup, next read beat prefetch, or a write beat.
    always_comb begin
        w_mem_en   = 1'b0;
        w_mem_we   = 4'b0000;
        w_mem_addr = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = w_ar_idx;
                end
            end
            S_READ: begin
                if (s_axi_rready && !w_last_beat) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = w_next_idx;
                end
            end
            S_WDATA: begin
                if (s_axi_wvalid) begin
                    w_mem_en = 1'b1;
                    w_mem_we = s_axi_wstrb;
                end
            end
            default: begin
                w_mem_en = 1'b0;
            end
        endcase
        if (reset) begin
            w_mem_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_burst <= AXI_BURST_FIXED;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id    <= s_axi_awid;
                        r_idx   <= w_aw_idx;
                        r_len   <= s_axi_awlen;
                        r_burst <= s_axi_awburst;
                        r_beat  <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_WDATA;
                    end else if (w_ar_hs) begin
                        r_id    <= s_axi_arid;
                        r_idx   <= w_ar_idx;
                        r_len   <= s_axi_arlen;
                        r_burst <= s_axi_arburst;
                        r_beat  <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (s_axi_rready) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_idx  <= w_next_idx;
                        end
                    end
                end
                S_WDATA: begin
                    if (s_axi_wvalid) begin
                        // The burst length comes from awlen; a misplaced wlast only flags an error.
                        if (s_axi_wlast != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                        r_idx <= w_next_idx;
                        if (w_last_beat) begin
                            r_state <= S_BRESP;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                S_BRESP: begin
                    if (s_axi_bready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    axi_ram_mem #(
        .ADDR_W (c_IDX_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .addr  (w_mem_addr),
        .wdata (s_axi_wdata),
        .rdata (w_mem_rdata)
    );

    assign w_unused = ^{s_axi_arsize, s_axi_awsize, s_axi_wid, s_axi_araddr, s_axi_awaddr};

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ram_responder
// Description : Directed and randomized checks of axi_ram_responder against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_ram_responder;

    localparam int DEPTH = 4096;
    localparam int TMO   = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_axi_arid, s_axi_awid, s_axi_wid, s_axi_rid, s_axi_bid;
    logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
    logic [7:0]  s_axi_arlen, s_axi_awlen;
    logic [2:0]  s_axi_arsize, s_axi_awsize;
    logic [1:0]  s_axi_arburst, s_axi_awburst, s_axi_rresp, s_axi_bresp;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem   [DEPTH];
    logic [3:0]  model_known [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;

    always #5 clk = ~clk;

    axi_ram_responder #(.MEM_WORDS_LOG2(12), .ID_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
    );

    // Word index of beat i of a burst, from the AXI address rules.
    function automatic int beat_idx(input logic [31:0] addr, input int len, input logic [1:0] burst, input int i);
        int s;
        int n;
        s = int'((addr >> 2) % DEPTH);
        n = len + 1;
        if (burst == 2'b00) return s;
        if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
            return (s - s % n) + (s % n + i) % n;
        return (s + i) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
        for (int b = 0; b <= len; b++) begin
            int k;
            k = beat_idx(addr, len, burst, b);
            for (int l = 0; l < 4; l++) begin
                if (ws[b][l]) begin
                    model_mem[k][8*l +: 8] = wd[b][8*l +: 8];
                    model_known[k][l]      = 1'b1;
                end
            end
        end
    endtask

    // Channel: 0 AW, 1 AR, 2 W, 3 B. Starts and ends just after a rising edge.
    task automatic wait_hs(input int ch, input string name);
        int t;
        bit done;
        t = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            case (ch)
                0: done = s_axi_awready;
                1: done = s_axi_arready;
                2: done = s_axi_wready;
                default: begin
                    done       = s_axi_bvalid;
                    last_bresp = s_axi_bresp;
                    last_bid   = s_axi_bid;
                end
            endcase
            @(posedge clk); #1;
            if (!done) begin
                t++;
                if (t > TMO) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s timeout: got no handshake in %0d cycles, required one", name, t);
                    done = 1;
                end
            end
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        s_axi_awburst = burst; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
        wait_hs(0, "aw");
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_phase(input int len, input int last_at, input bit gaps);
        for (int b = 0; b <= len; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axi_wvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wd[b];
            s_axi_wstrb  = ws[b];
            s_axi_wid    = 4'($urandom);
            s_axi_wlast  = (last_at < 0) ? (b == len) : (b == last_at);
            wait_hs(2, "w");
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic b_phase(input int delay);
        s_axi_bready = 1'b0;
        repeat (delay) begin @(posedge clk); #1; end
        s_axi_bready = 1'b1;
        wait_hs(3, "b");
        s_axi_bready = 1'b0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        s_axi_arburst = burst; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
        wait_hs(1, "ar");
        s_axi_arvalid = 1'b0;
    endtask

    // Collects len+1 beats; cycles counts R-phase cycles from the one after AR acceptance.
    task automatic r_phase(input int len, input logic [31:0] rpat, output int nb, output int cycles, output bit unstable);
        logic [31:0] pd;
        logic        pl;
        bit          stalled;
        int          k;
        nb = 0; cycles = 0; unstable = 0; stalled = 0; k = 0; pd = '0; pl = 1'b0;
        while (nb <= len && cycles < TMO) begin
            s_axi_rready = rpat[k % 32];
            k++;
            @(negedge clk);
            cycles++;
            if (stalled && s_axi_rvalid && (s_axi_rdata !== pd || s_axi_rlast !== pl)) unstable = 1;
            stalled = 0;
            if (s_axi_rvalid === 1'b1) begin
                if (s_axi_rready) begin
                    rd_data[nb] = s_axi_rdata;
                    rd_last[nb] = s_axi_rlast;
                    rd_id[nb]   = s_axi_rid;
                    nb++;
                end else begin
                    stalled = 1;
                    pd = s_axi_rdata;
                    pl = s_axi_rlast;
                end
            end
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b0;
        if (nb <= len) begin
            n_tests++; n_fail++;
            $display("FAIL r timeout: got %0d beats, required %0d", nb, len + 1);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_rlast} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b required 000000",
                {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_rlast});
        end
        n_tests++;
        if ({s_axi_rid, s_axi_bid, s_axi_rresp, s_axi_bresp} !== 12'h000) begin
            n_fail++; $display("FAIL reset_ids: got %h required 000", {s_axi_rid, s_axi_bid, s_axi_rresp, s_axi_bresp});
        end
        n_tests++;
        if (s_axi_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h required 00000000", s_axi_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            n_fail++; $display("FAIL idle_ready: got %b required 11", {s_axi_awready, s_axi_arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int nb, cyc;
        bit un;
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        aw_phase(4'd5, 32'h100, 0, 2'b01); w_phase(0, -1, 0); b_phase(0);
        model_write(32'h100, 0, 2'b01);
        n_tests++;
        if (last_bresp !== 2'b00 || last_bid !== 4'd5) begin
            n_fail++; $display("FAIL single_b: got resp %b id %0d required resp 00 id 5", last_bresp, last_bid);
        end
        ar_phase(4'd9, 32'h100, 0, 2'b01); r_phase(0, 32'hFFFFFFFF, nb, cyc, un);
        n_tests++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_id[0] !== 4'd9) begin
            n_fail++; $display("FAIL single_r: got %h last %b id %0d required deadbeef last 1 id 9", rd_data[0], rd_last[0], rd_id[0]);
        end
        n_tests++;
        if (cyc !== 1) begin
            n_fail++; $display("FAIL single_latency: got %0d cycles required 1", cyc);
        end
    endtask

    task automatic test_incr4;
        int nb, cyc;
        bit un;
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        aw_phase(4'd1, 32'h200, 3, 2'b01); w_phase(3, -1, 0); b_phase(0);
        model_write(32'h200, 3, 2'b01);
        n_tests++;
        if (last_bresp !== 2'b00 || last_bid !== 4'd1) begin
            n_fail++; $display("FAIL incr4_b: got resp %b id %0d required resp 00 id 1", last_bresp, last_bid);
        end
        ar_phase(4'd6, 32'h200, 3, 2'b01); r_phase(3, 32'hFFFFFFFF, nb, cyc, un);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++; $display("FAIL incr4_throughput: got %0d cycles required 4", cyc);
        end
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (rd_data[b] !== 32'(b + 1) || rd_last[b] !== (b == 3)) begin
                n_fail++; $display("FAIL incr4_beat%0d: got %h last %b required %h last %b", b, rd_data[b], rd_last[b], b + 1, b == 3);
            end
        end
        @(negedge clk);
        n_tests++;
        if (s_axi_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL incr4_extra_beat: got rvalid %b required 0", s_axi_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_strobe;
        int nb, cyc;
        bit un;
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        aw_phase(4'd2, 32'h300, 0, 2'b01); w_phase(0, -1, 0); b_phase(0);
        wd[0] = 32'h0000AB00; ws[0] = 4'b0010;
        aw_phase(4'd2, 32'h300, 0, 2'b01); w_phase(0, -1, 0); b_phase(1);
        ar_phase(4'd2, 32'h300, 0, 2'b01); r_phase(0, 32'hFFFFFFFF, nb, cyc, un);
        n_tests++;
        if (rd_data[0] !== 32'hFFFFABFF) begin
            n_fail++; $display("FAIL strobe: got %h required ffffabff", rd_data[0]);
        end
        model_mem[12'h0C0] = 32'hFFFFABFF; model_known[12'h0C0] = 4'hF;
    endtask

    task automatic test_backpressure;
        int nb, cyc;
        bit un;
        ar_phase(4'd7, 32'h200, 3, 2'b01); r_phase(3, 32'h99999999, nb, cyc, un);
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (rd_data[b] !== 32'(b + 1) || rd_last[b] !== (b == 3)) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h last %b required %h last %b", b, rd_data[b], rd_last[b], b + 1, b == 3);
            end
        end
        n_tests++;
        if (un !== 1'b0 || cyc !== 8) begin
            n_fail++; $display("FAIL bp_stall: got unstable %b cycles %0d required unstable 0 cycles 8", un, cyc);
        end
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        aw_phase(4'd8, 32'h280, 0, 2'b01); w_phase(0, -1, 0);
        model_write(32'h280, 0, 2'b01);
        s_axi_bready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({s_axi_bvalid, s_axi_awready, s_axi_arready} !== 3'b100) begin
                n_fail++; $display("FAIL bp_bresp_hold%0d: got %b required 100", c, {s_axi_bvalid, s_axi_awready, s_axi_arready});
            end
            @(posedge clk); #1;
        end
        b_phase(0);
        n_tests++;
        if (last_bresp !== 2'b00 || last_bid !== 4'd8) begin
            n_fail++; $display("FAIL bp_b: got resp %b id %0d required resp 00 id 8", last_bresp, last_bid);
        end
    endtask

    task automatic test_simultaneous;
        int nb, cyc;
        bit un;
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        s_axi_arid = 4'd3; s_axi_araddr = 32'h400; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        s_axi_awid = 4'd4; s_axi_awaddr = 32'h400; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({s_axi_awready, s_axi_arready} !== 2'b10) begin
            n_fail++; $display("FAIL sim_priority: got %b required 10", {s_axi_awready, s_axi_arready});
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (s_axi_arready !== 1'b0) begin
            n_fail++; $display("FAIL sim_ar_blocked: got arready %b required 0", s_axi_arready);
        end
        @(posedge clk); #1;
        w_phase(0, -1, 0);
        b_phase(2);
        model_write(32'h400, 0, 2'b01);
        @(negedge clk);
        n_tests++;
        if (s_axi_arready !== 1'b1) begin
            n_fail++; $display("FAIL sim_ar_after_b: got arready %b required 1", s_axi_arready);
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        r_phase(0, 32'hFFFFFFFF, nb, cyc, un);
        n_tests++;
        if (rd_data[0] !== 32'h12345678 || rd_id[0] !== 4'd3) begin
            n_fail++; $display("FAIL sim_readback: got %h id %0d required 12345678 id 3", rd_data[0], rd_id[0]);
        end
    endtask

    task automatic test_wrap;
        int nb, cyc;
        bit un;
        logic [31:0] exp_w [4];
        exp_w = '{32'd3, 32'd4, 32'd1, 32'd2};
        ar_phase(4'd10, 32'h208, 3, 2'b10); r_phase(3, 32'hFFFFFFFF, nb, cyc, un);
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (rd_data[b] !== exp_w[b]) begin
                n_fail++; $display("FAIL wrap_beat%0d: got %h required %h", b, rd_data[b], exp_w[b]);
            end
        end
    endtask

    task automatic test_wlast_err;
        int nb, cyc;
        bit un;
        wd[0] = 32'hA1A1A1A1; wd[1] = 32'hB2B2B2B2; ws[0] = 4'hF; ws[1] = 4'hF;
        aw_phase(4'd11, 32'h500, 1, 2'b01); w_phase(1, 0, 0); b_phase(0);
        model_write(32'h500, 1, 2'b01);
        n_tests++;
        if (last_bresp !== 2'b10 || last_bid !== 4'd11) begin
            n_fail++; $display("FAIL wlast_err_b: got resp %b id %0d required resp 10 id 11", last_bresp, last_bid);
        end
        ar_phase(4'd11, 32'h500, 1, 2'b01); r_phase(1, 32'hFFFFFFFF, nb, cyc, un);
        n_tests++;
        if (rd_data[0] !== 32'hA1A1A1A1 || rd_data[1] !== 32'hB2B2B2B2) begin
            n_fail++; $display("FAIL wlast_err_data: got %h %h required a1a1a1a1 b2b2b2b2", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_reset_mid_read;
        int nb, cyc;
        bit un;
        ar_phase(4'd12, 32'h200, 3, 2'b01);
        s_axi_rready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({s_axi_rvalid, s_axi_awready} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_read: got rvalid,awready %b required 00", {s_axi_rvalid, s_axi_awready});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({s_axi_awready, s_axi_arready, s_axi_rvalid, s_axi_bvalid} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_idle: got %b required 1100", {s_axi_awready, s_axi_arready, s_axi_rvalid, s_axi_bvalid});
        end
        @(posedge clk); #1;
        ar_phase(4'd13, 32'h204, 0, 2'b01); r_phase(0, 32'hFFFFFFFF, nb, cyc, un);
        n_tests++;
        if (rd_data[0] !== 32'd2 || rd_id[0] !== 4'd13) begin
            n_fail++; $display("FAIL rst_recover: got %h id %0d required 00000002 id 13", rd_data[0], rd_id[0]);
        end
    endtask

    task automatic test_random;
        int lens [6];
        for (int it = 0; it < 60; it++) begin
            logic [3:0]  id;
            logic [1:0]  burst;
            logic [31:0] addr;
            int          len;
            lens  = '{0, 1, 3, 7, 15, 0};
            lens[5] = $urandom_range(0, 15);
            id    = 4'($urandom);
            burst = 2'($urandom_range(0, 3));
            len   = lens[$urandom_range(0, 5)];
            addr  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            if (it < 8 || $urandom_range(0, 1) == 1) begin
                int last_at;
                logic [1:0] exp_resp;
                for (int b = 0; b <= len; b++) begin
                    wd[b] = $urandom;
                    ws[b] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                end
                last_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
                exp_resp = (last_at >= 0 && last_at != len) ? 2'b10 : 2'b00;
                aw_phase(id, addr, len, burst);
                w_phase(len, last_at, 1);
                b_phase($urandom_range(0, 3));
                model_write(addr, len, burst);
                n_tests++;
                if (last_bresp !== exp_resp || last_bid !== id) begin
                    n_fail++; $display("FAIL rnd%0d_b: got resp %b id %0d required resp %b id %0d", it, last_bresp, last_bid, exp_resp, id);
                end
            end else begin
                int nb, cyc;
                bit un;
                ar_phase(id, addr, len, burst);
                r_phase(len, $urandom | 32'h1, nb, cyc, un);
                n_tests++;
                if (un !== 1'b0) begin
                    n_fail++; $display("FAIL rnd%0d_stable: got unstable %b required 0", it, un);
                end
                for (int b = 0; b < nb; b++) begin
                    int          k;
                    logic [31:0] m;
                    k = beat_idx(addr, len, burst, b);
                    m = {{8{model_known[k][3]}}, {8{model_known[k][2]}}, {8{model_known[k][1]}}, {8{model_known[k][0]}}};
                    n_tests++;
                    if (rd_id[b] !== id || rd_last[b] !== (b == len) ||
                        (m != 32'h0 && (rd_data[b] & m) !== (model_mem[k] & m))) begin
                        n_fail++; $display("FAIL rnd%0d_beat%0d: got data %h id %0d last %b required data %h (mask %h) id %0d last %b",
                            it, b, rd_data[b], rd_id[b], rd_last[b], model_mem[k], m, id, b == len);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_known[i] = 4'h0; end
        reset = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awvalid = 1'b0; s_axi_wid = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        last_bresp = '0; last_bid = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_single;
        test_incr4;
        test_strobe;
        test_backpressure;
        test_simultaneous;
        test_wrap;
        test_wlast_err;
        test_reset_mid_read;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
